// File: rtl/bp_fe_trace_packer_pkg.sv
// +----------------------------------------------------------------------------+
// | bp_fe_trace_packer_pkg: opcodes, FSM states and packet layout for the       |
// | FE trace packer.                                          Revision: 1.0     |
// +----------------------------------------------------------------------------+
`default_nettype none

package bp_fe_trace_packer_pkg;

  typedef enum logic [1:0] {
    e_trace_nop      = 2'd0,
    e_trace_redirect = 2'd1
  } bp_fe_trace_cmd_e;

  typedef enum logic [1:0] {
    e_ready = 2'd0,
    e_send  = 2'd1,
    e_cmd   = 2'd2,
    e_flush = 2'd3
  } bp_fe_trace_state_e;

  typedef enum logic [1:0] {
    e_fe_fetch     = 2'd0,
    e_fe_exception = 2'd1
  } bp_fe_queue_type_e;

  typedef enum logic [2:0] {
    e_op_state_reset    = 3'd0,
    e_op_pc_redirection = 3'd1
  } bp_fe_command_queue_opcode_e;

  localparam int fe_msg_type_width_lp = 2;
  localparam int fe_cmd_opcode_width_lp = 3;
  localparam int instr_width_lp = 32;

  // Trace packet layout, LSB first: instruction, then PC, then zero pad.
  localparam int pkt_instr_offset_lp = 0;
  localparam int pkt_pc_offset_lp    = instr_width_lp;

endpackage

`default_nettype wire

// File: rtl/bp_fe_trace_sat_counter.sv
// +----------------------------------------------------------------------------+
// | bp_fe_trace_sat_counter: up counter that sticks at all-ones.                |
// |                                                           Revision: 1.0     |
// +----------------------------------------------------------------------------+
`default_nettype none

module bp_fe_trace_sat_counter #(
  parameter int width_p = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en_i,
  output logic [width_p-1:0] count_o
);

  always_ff @(posedge clk) begin
    if (reset)
      count_o <= '0;
    else if (en_i && !(&count_o))
      count_o <= count_o + 1'b1;
  end

endmodule

`default_nettype wire

// File: rtl/bp_fe_trace_packer.sv
// +----------------------------------------------------------------------------+
// | bp_fe_trace_packer: packs FE queue fetches into replay packets and turns    |
// | replay redirects into FE PC-redirect commands. Optional stall injection:    |
// | BP_FE_TRACE_PACKER_STALL_INJECT_EN.                       Revision: 1.0     |
// +----------------------------------------------------------------------------+
`default_nettype none

module bp_fe_trace_packer
  import bp_fe_trace_packer_pkg::*;
#(
  parameter int vaddr_width_p               = 39,
  parameter int paddr_width_p               = 22,
  parameter int asid_width_p                = 10,
  parameter int branch_metadata_fwd_width_p = 36,
  parameter int trace_ring_width_p          = 80,
  parameter int cnt_width_p                 = 32,
  localparam int fe_queue_width_lp = fe_msg_type_width_lp + vaddr_width_p + instr_width_lp
                                   + branch_metadata_fwd_width_p,
  localparam int fe_cmd_width_lp   = fe_cmd_opcode_width_lp + vaddr_width_p + paddr_width_p
                                   + asid_width_p + branch_metadata_fwd_width_p
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [fe_queue_width_lp-1:0]  fe_queue_i,
  input  logic                          fe_queue_v_i,
  output logic                          fe_queue_yumi_o,
  output logic                          fe_queue_clr_o,
  output logic [fe_cmd_width_lp-1:0]    fe_cmd_o,
  output logic                          fe_cmd_v_o,
  input  logic                          fe_cmd_ready_i,
  output logic [trace_ring_width_p-1:0] trace_data_o,
  output logic                          trace_v_o,
  input  logic                          trace_ready_i,
  input  logic [trace_ring_width_p-1:0] trace_data_i,
  input  logic                          trace_v_i,
  output logic                          trace_yumi_o,
  output logic [cnt_width_p-1:0]        instr_cnt_o,
  output logic [cnt_width_p-1:0]        drop_cnt_o
);

  if (trace_ring_width_p < vaddr_width_p + instr_width_lp) begin : g_bad_ring_width
    $error("trace_ring_width_p must be >= vaddr_width_p+32");
  end

  // FE queue entry, MSB first: {msg_type, pc, instr, branch_metadata}.
  localparam int q_instr_lsb_lp = branch_metadata_fwd_width_p;
  localparam int q_pc_lsb_lp    = q_instr_lsb_lp + instr_width_lp;
  localparam int q_type_lsb_lp  = q_pc_lsb_lp + vaddr_width_p;

  bp_fe_trace_state_e state_r;

  logic [fe_msg_type_width_lp-1:0] q_msg_type;
  logic [vaddr_width_p-1:0]        q_pc, redirect_pc;
  logic [instr_width_lp-1:0]       q_instr;
  logic [1:0]                      cmd_opcode;
  logic                            q_is_fetch, stall, instr_inc, drop_inc;
  logic [trace_ring_width_p-1:0]   pkt_next;
  logic [fe_cmd_width_lp-1:0]      cmd_next;
  logic                            unused_bits;

  assign q_msg_type  = fe_queue_i[q_type_lsb_lp +: fe_msg_type_width_lp];
  assign q_pc        = fe_queue_i[q_pc_lsb_lp +: vaddr_width_p];
  assign q_instr     = fe_queue_i[q_instr_lsb_lp +: instr_width_lp];
  assign q_is_fetch  = (q_msg_type == e_fe_fetch);
  assign cmd_opcode  = trace_data_i[1:0];
  assign redirect_pc = trace_data_i[vaddr_width_p+1:2];
  assign unused_bits = ^{trace_data_i[trace_ring_width_p-1:vaddr_width_p+2],
                         fe_queue_i[branch_metadata_fwd_width_p-1:0]};

`ifdef BP_FE_TRACE_PACKER_STALL_INJECT_EN
  logic [15:0] lfsr_r;
  always_ff @(posedge clk) begin
    if (reset)
      lfsr_r <= 16'hACE1;
    else
      lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
  end
  assign stall = (lfsr_r[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    pkt_next = '0;
    pkt_next[pkt_instr_offset_lp +: instr_width_lp] = q_instr;
    pkt_next[pkt_pc_offset_lp +: vaddr_width_p]     = q_pc;
    cmd_next = '0;
    cmd_next[fe_cmd_width_lp-1 -: fe_cmd_opcode_width_lp] = e_op_pc_redirection;
    cmd_next[fe_cmd_width_lp-1-fe_cmd_opcode_width_lp -: vaddr_width_p] = redirect_pc;
  end

  // Replay commands win over the FE queue; in SEND a new entry is only taken
  // on the cycle the current packet leaves.
  always_comb begin
    fe_queue_yumi_o = 1'b0;
    case (state_r)
      e_ready: fe_queue_yumi_o = !trace_v_i && fe_queue_v_i && !stall;
      e_send:  fe_queue_yumi_o = trace_ready_i && !trace_v_i && fe_queue_v_i
                                 && q_is_fetch && !stall;
      default: fe_queue_yumi_o = 1'b0;
    endcase
  end

  assign trace_yumi_o   = (state_r == e_ready) && trace_v_i;
  assign trace_v_o      = (state_r == e_send);
  assign fe_cmd_v_o     = (state_r == e_cmd);
  assign fe_queue_clr_o = (state_r == e_flush);
  assign instr_inc      = (state_r == e_send) && trace_ready_i;
  assign drop_inc       = (state_r == e_ready) && fe_queue_yumi_o && !q_is_fetch;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= e_ready;
      trace_data_o <= '0;
      fe_cmd_o     <= '0;
    end else begin
      case (state_r)
        e_ready: begin
          if (trace_v_i) begin
            if (cmd_opcode == e_trace_redirect) begin
              fe_cmd_o <= cmd_next;
              state_r  <= e_cmd;
            end
          end else if (fe_queue_yumi_o && q_is_fetch) begin
            trace_data_o <= pkt_next;
            state_r      <= e_send;
          end
        end
        e_send: begin
          if (trace_ready_i) begin
            if (fe_queue_yumi_o)
              trace_data_o <= pkt_next;
            else
              state_r <= e_ready;
          end
        end
        e_cmd: begin
          if (fe_cmd_ready_i)
            state_r <= e_flush;
        end
        default: state_r <= e_ready;
      endcase
    end
  end

  bp_fe_trace_sat_counter #(.width_p(cnt_width_p)) u_instr_cnt (
    .clk     (clk),
    .reset   (reset),
    .en_i    (instr_inc),
    .count_o (instr_cnt_o)
  );

  bp_fe_trace_sat_counter #(.width_p(cnt_width_p)) u_drop_cnt (
    .clk     (clk),
    .reset   (reset),
    .en_i    (drop_inc),
    .count_o (drop_cnt_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_bp_fe_trace_packer.sv
// +----------------------------------------------------------------------------+
// | tb_bp_fe_trace_packer: directed self-checking bench for bp_fe_trace_packer. |
// |                                                           Revision: 1.0     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_bp_fe_trace_packer;

  localparam int VW  = 39;
  localparam int BMW = 36;
  localparam int RW  = 80;
  localparam int CW  = 3;
  localparam int QW  = 2 + VW + 32 + BMW;
  localparam int CMW = 3 + VW + 22 + 10 + BMW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [QW-1:0] fe_queue_i = '0;
  logic          fe_queue_v_i = 1'b0;
  logic          fe_queue_yumi_o, fe_queue_clr_o;
  logic [CMW-1:0] fe_cmd_o;
  logic          fe_cmd_v_o;
  logic          fe_cmd_ready_i = 1'b0;
  logic [RW-1:0] trace_data_o;
  logic          trace_v_o;
  logic          trace_ready_i = 1'b0;
  logic [RW-1:0] trace_data_i = '0;
  logic          trace_v_i = 1'b0;
  logic          trace_yumi_o;
  logic [CW-1:0] instr_cnt_o, drop_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  bp_fe_trace_packer #(.cnt_width_p(CW)) dut (
    .clk             (clk),
    .reset           (reset),
    .fe_queue_i      (fe_queue_i),
    .fe_queue_v_i    (fe_queue_v_i),
    .fe_queue_yumi_o (fe_queue_yumi_o),
    .fe_queue_clr_o  (fe_queue_clr_o),
    .fe_cmd_o        (fe_cmd_o),
    .fe_cmd_v_o      (fe_cmd_v_o),
    .fe_cmd_ready_i  (fe_cmd_ready_i),
    .trace_data_o    (trace_data_o),
    .trace_v_o       (trace_v_o),
    .trace_ready_i   (trace_ready_i),
    .trace_data_i    (trace_data_i),
    .trace_v_i       (trace_v_i),
    .trace_yumi_o    (trace_yumi_o),
    .instr_cnt_o     (instr_cnt_o),
    .drop_cnt_o      (drop_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [QW-1:0] entry(input logic [1:0] msg, input logic [VW-1:0] pc,
                                          input logic [31:0] instr);
    return {msg, pc, instr, {BMW{1'b0}}};
  endfunction

  function automatic logic [RW-1:0] pkt(input logic [VW-1:0] pc, input logic [31:0] instr);
    return {{(RW-VW-32){1'b0}}, pc, instr};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [VW-1:0] pcs [5];
  logic [31:0]   ins [5];
  logic [CMW-1:0] exp_cmd;

  initial begin
    pcs[0] = 39'h80000124; ins[0] = 32'h00a00513;
    pcs[1] = 39'h80000128; ins[1] = 32'h00b00593;
    pcs[2] = 39'h8000012c; ins[2] = 32'h00c00613;
    pcs[3] = 39'h80000130; ins[3] = 32'h00d00693;
    pcs[4] = 39'h80000134; ins[4] = 32'h00e00713;

    // Reset state
    repeat (3) next_cycle();
    @(negedge clk);
    check("rst_trace_v", trace_v_o, 0);
    check("rst_cmd_v", fe_cmd_v_o, 0);
    check("rst_clr", fe_queue_clr_o, 0);
    check("rst_qyumi", fe_queue_yumi_o, 0);
    check("rst_tyumi", trace_yumi_o, 0);
    check("rst_tdata", trace_data_o, 0);
    check("rst_cmd", fe_cmd_o, 0);
    check("rst_icnt", instr_cnt_o, 0);
    check("rst_dcnt", drop_cnt_o, 0);
    next_cycle();
    reset = 1'b0;

    // Single fetch, latency yumi N -> trace_v N+1
    trace_ready_i = 1'b1;
    fe_queue_i = entry(2'd0, pcs[0], ins[0]);
    fe_queue_v_i = 1'b1;
    @(negedge clk);
    check("one_yumi", fe_queue_yumi_o, 1);
    check("one_v_early", trace_v_o, 0);
    next_cycle();
    fe_queue_v_i = 1'b0;
    @(negedge clk);
    check("one_v", trace_v_o, 1);
    check("one_low71", trace_data_o[70:0], {39'h80000124, 32'h00a00513});
    check("one_data", trace_data_o, pkt(39'h80000124, 32'h00a00513));
    next_cycle();
    @(negedge clk);
    check("one_v_done", trace_v_o, 0);
    check("one_icnt", instr_cnt_o, 1);

    // Four back-to-back fetches
    next_cycle();
    fe_queue_i = entry(2'd0, pcs[1], ins[1]);
    fe_queue_v_i = 1'b1;
    @(negedge clk);
    check("b2b_yumi0", fe_queue_yumi_o, 1);
    for (int i = 1; i <= 4; i++) begin
      next_cycle();
      if (i < 4) fe_queue_i = entry(2'd0, pcs[i+1], ins[i+1]);
      else fe_queue_v_i = 1'b0;
      @(negedge clk);
      check("b2b_v", trace_v_o, 1);
      check("b2b_data", trace_data_o, pkt(pcs[i], ins[i]));
      check("b2b_yumi", fe_queue_yumi_o, (i < 4) ? 1 : 0);
    end
    next_cycle();
    @(negedge clk);
    check("b2b_v_done", trace_v_o, 0);
    check("b2b_icnt", instr_cnt_o, 5);

    // Backpressure: hold trace_ready_i low for 5 cycles
    next_cycle();
    trace_ready_i = 1'b0;
    fe_queue_i = entry(2'd0, pcs[0], ins[0]);
    fe_queue_v_i = 1'b1;
    @(negedge clk);
    check("bp_yumi", fe_queue_yumi_o, 1);
    next_cycle();
    fe_queue_i = entry(2'd0, pcs[1], ins[1]);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_v", trace_v_o, 1);
      check("bp_hold_data", trace_data_o, pkt(pcs[0], ins[0]));
      check("bp_hold_yumi", fe_queue_yumi_o, 0);
      next_cycle();
    end
    trace_ready_i = 1'b1;
    @(negedge clk);
    check("bp_rel_yumi", fe_queue_yumi_o, 1);
    check("bp_icnt_hold", instr_cnt_o, 5);
    next_cycle();
    fe_queue_v_i = 1'b0;
    @(negedge clk);
    check("bp_next_data", trace_data_o, pkt(pcs[1], ins[1]));
    check("bp_icnt_once", instr_cnt_o, 6);
    next_cycle();
    @(negedge clk);
    check("bp_v_done", trace_v_o, 0);
    check("bp_icnt", instr_cnt_o, 7);

    // Redirect with FE queue entry pending at the same time
    next_cycle();
    trace_data_i = '0;
    trace_data_i[VW+1:0] = {39'h80000200, 2'b01};
    trace_v_i = 1'b1;
    fe_queue_i = entry(2'd0, pcs[2], ins[2]);
    fe_queue_v_i = 1'b1;
    fe_cmd_ready_i = 1'b0;
    exp_cmd = '0;
    exp_cmd[CMW-1 -: 3] = 3'd1;
    exp_cmd[CMW-4 -: VW] = 39'h80000200;
    @(negedge clk);
    check("rd_tyumi", trace_yumi_o, 1);
    check("rd_qyumi", fe_queue_yumi_o, 0);
    next_cycle();
    trace_data_i[1:0] = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("cmd_v", fe_cmd_v_o, 1);
      check("cmd_data", fe_cmd_o, exp_cmd);
      check("cmd_qyumi", fe_queue_yumi_o, 0);
      check("cmd_tyumi", trace_yumi_o, 0);
      next_cycle();
    end
    fe_cmd_ready_i = 1'b1;
    @(negedge clk);
    check("cmd_v_acc", fe_cmd_v_o, 1);
    check("cmd_clr_early", fe_queue_clr_o, 0);
    next_cycle();
    fe_cmd_ready_i = 1'b0;
    @(negedge clk);
    check("fl_clr", fe_queue_clr_o, 1);
    check("fl_cmd_v", fe_cmd_v_o, 0);
    check("fl_qyumi", fe_queue_yumi_o, 0);
    check("fl_tyumi", trace_yumi_o, 0);
    next_cycle();
    @(negedge clk);
    check("fl_clr_once", fe_queue_clr_o, 0);
    check("nop_tyumi", trace_yumi_o, 1);
    check("nop_qyumi", fe_queue_yumi_o, 0);
    next_cycle();
    trace_v_i = 1'b0;
    @(negedge clk);
    check("nop_stay", fe_cmd_v_o, 0);
    check("post_qyumi", fe_queue_yumi_o, 1);
    next_cycle();
    fe_queue_v_i = 1'b0;
    @(negedge clk);
    check("post_data", trace_data_o, pkt(pcs[2], ins[2]));
    next_cycle();
    @(negedge clk);
    check("icnt_sat", instr_cnt_o, 7);

    // Non-fetch entries dropped, counter saturates
    next_cycle();
    fe_queue_i = entry(2'd1, pcs[3], ins[3]);
    fe_queue_v_i = 1'b1;
    @(negedge clk);
    check("drop_yumi", fe_queue_yumi_o, 1);
    next_cycle();
    @(negedge clk);
    check("drop_no_pkt", trace_v_o, 0);
    check("drop_cnt1", drop_cnt_o, 1);
    repeat (8) next_cycle();
    fe_queue_v_i = 1'b0;
    @(negedge clk);
    check("drop_sat", drop_cnt_o, 7);
    check("drop_sat_v", trace_v_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
